feed_port_arbiter: RTL and testbench

- Frame-granular round-robin arbiter that shares the single byte-stream packet parser between N_PORTS ingress feed ports (e.g. A/B redundant market-data lines).
- Each port presents a byte stream with valid/ready/last; the arbiter grants one port, locks the grant until that port's tlast beat is accepted, then rotates priority.
- Sits directly upstream of the parser and drives its tdata/tvalid/tlast inputs, plus a source-port tag.

---
 rtl/feed_port_arbiter_if.sv | 30 +++
 rtl/feed_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_feed_port_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/feed_port_arbiter_if.sv
// Stream bundle shared by the ingress feed ports, the feed port arbiter and
// the downstream byte-stream parser. Port i of s_tdata occupies [8i+7:8i].
interface feed_port_arbiter_if #(
   parameter int N_PORTS = 2,
   parameter int ID_W    = 3
);
   logic [N_PORTS*8-1:0] s_tdata;
   logic [N_PORTS-1:0]   s_tvalid;
   logic [N_PORTS-1:0]   s_tlast;
   logic [N_PORTS-1:0]   s_tready;
   logic [7:0]           m_tdata;
   logic                 m_tvalid;
   logic                 m_tlast;
   logic                 m_tready;
   logic [ID_W-1:0]      m_tid;
   logic                 m_tabort;
   logic [15:0]          frame_count;

   // Arbiter view: consumes the feed ports and drives the parser side.
   modport slave (
      input  s_tdata, s_tvalid, s_tlast, m_tready,
      output s_tready, m_tdata, m_tvalid, m_tlast, m_tid, m_tabort, frame_count
   );

   // Environment view: feed ports plus parser.
   modport master (
      output s_tdata, s_tvalid, s_tlast, m_tready,
      input  s_tready, m_tdata, m_tvalid, m_tlast, m_tid, m_tabort, frame_count
   );
endinterface

// File: rtl/feed_port_arbiter.sv
// Frame-granular round-robin arbiter in front of the byte-stream parser.
// A port is granted after a one-cycle arbitration bubble, the grant is held
// until that port's tlast beat, then priority rotates to grant+1.
// Optional watchdog: define FEED_ARB_TIMEOUT_EN to abort a granted frame
// whose port stays idle for TIMEOUT cycles (emits one 0x00/tlast/tabort beat).
module feed_port_arbiter #(
   parameter int N_PORTS = 2,
   parameter int ID_W    = 3,
   parameter int TIMEOUT = 64
) (
   input logic               clk,
   input logic               rst_n,
   feed_port_arbiter_if.slave bus
);

   if (N_PORTS < 2 || N_PORTS > 8 || (1 << ID_W) < N_PORTS || TIMEOUT < 1) begin : g_param_check
      $error("feed_port_arbiter: illegal N_PORTS/ID_W/TIMEOUT combination");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCKED = 2'd1
`ifdef FEED_ARB_TIMEOUT_EN
      , ABORT = 2'd2
`endif
   } state_e;

   state_e             state_q, state_d;
   logic [ID_W-1:0]    grant_q, grant_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [15:0]        frame_count_q, frame_count_d;

   logic [ID_W-1:0]    ptr_eff;
   logic [ID_W-1:0]    req_sel;
   logic [ID_W-1:0]    hi_sel, lo_sel;
   logic               hi_found;
   logic               req_any;

   logic [N_PORTS-1:0] grant_oh;
   logic [ID_W-1:0]    grant_inc;
   logic [7:0]         gnt_data;
   logic               gnt_valid, gnt_last, gnt_beat;

   logic [N_PORTS-1:0] s_tready;
   logic [7:0]         m_tdata;
   logic               m_tvalid, m_tlast, m_tabort;

`ifdef FEED_ARB_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   logic [TMR_W-1:0]   timer_q, timer_d;
`endif

   // Round-robin pick: lowest requester at or above ptr, else lowest overall.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path
      // leaves one unassigned and no latch is inferred.
      ptr_eff  = (int'(ptr_q) >= N_PORTS) ? '0 : ptr_q;
      req_any  = |bus.s_tvalid;
      hi_found = 1'b0;
      hi_sel   = '0;
      lo_sel   = '0;
      // Descending scan so the last hit is the lowest matching index.
      for (int i = N_PORTS - 1; i >= 0; i--) begin
         if (bus.s_tvalid[i]) begin
            lo_sel = ID_W'(i);
            if (ID_W'(i) >= ptr_eff) begin
               hi_sel   = ID_W'(i);
               hi_found = 1'b1;
            end
         end
      end
      req_sel = hi_found ? hi_sel : lo_sel;
   end

   // Select the granted port's byte stream and the post-frame priority.
   always_comb begin
      grant_oh  = '0;
      gnt_data  = '0;
      gnt_valid = 1'b0;
      gnt_last  = 1'b0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (grant_q == ID_W'(i)) begin
            grant_oh[i] = 1'b1;
            gnt_data    = bus.s_tdata[i*8 +: 8];
            gnt_valid   = bus.s_tvalid[i];
            gnt_last    = bus.s_tlast[i];
         end
      end
      gnt_beat  = gnt_valid & bus.m_tready;
      grant_inc = (int'(grant_q) >= N_PORTS - 1) ? '0 : grant_q + ID_W'(1);
   end

   // Next-state and output decode for the grant FSM.
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      ptr_d         = ptr_q;
      frame_count_d = frame_count_q;
      s_tready      = '0;
      m_tdata       = '0;
      m_tvalid      = 1'b0;
      m_tlast       = 1'b0;
      m_tabort      = 1'b0;
`ifdef FEED_ARB_TIMEOUT_EN
      timer_d       = timer_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (req_any) begin
               grant_d = req_sel;
               state_d = LOCKED;
`ifdef FEED_ARB_TIMEOUT_EN
               timer_d = '0;
`endif
            end
         end
         LOCKED: begin
            // Zero-latency pass-through from the granted port.
            m_tdata  = gnt_data;
            m_tvalid = gnt_valid;
            m_tlast  = gnt_last;
            s_tready = grant_oh & {N_PORTS{bus.m_tready}};
            if (gnt_beat && gnt_last) begin
               state_d       = IDLE;
               ptr_d         = grant_inc;
               frame_count_d = frame_count_q + 16'd1;
            end
`ifdef FEED_ARB_TIMEOUT_EN
            else if (gnt_beat) begin
               timer_d = '0;
            end else if (!gnt_valid) begin
               timer_d = timer_q + TMR_W'(1);
               if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                  state_d = ABORT;
               end
            end
`endif
         end
`ifdef FEED_ARB_TIMEOUT_EN
         ABORT: begin
            // Synthetic terminating beat so the parser sees the frame end.
            m_tvalid = 1'b1;
            m_tlast  = 1'b1;
            m_tabort = 1'b1;
            if (bus.m_tready) begin
               state_d = IDLE;
               ptr_d   = grant_inc;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // State, grant, priority pointer and frame counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         ptr_q         <= '0;
         frame_count_q <= '0;
`ifdef FEED_ARB_TIMEOUT_EN
         timer_q       <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values of the others.
         state_q       <= state_d;
         grant_q       <= grant_d;
         ptr_q         <= ptr_d;
         frame_count_q <= frame_count_d;
`ifdef FEED_ARB_TIMEOUT_EN
         timer_q       <= timer_d;
`endif
      end
   end

   assign bus.s_tready    = s_tready;
   assign bus.m_tdata     = m_tdata;
   assign bus.m_tvalid    = m_tvalid;
   assign bus.m_tlast     = m_tlast;
   assign bus.m_tabort    = m_tabort;
   assign bus.m_tid       = grant_q;
   assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_feed_port_arbiter.sv
// Self-checking bench for feed_port_arbiter. Port drivers push each frame's
// bytes into a per-port expected queue; a negedge monitor tracks grants at
// frame level (round-robin from a pointer) and pops/compares every beat.
module tb_feed_port_arbiter;
   localparam int N       = 2;
   localparam int ID_W    = 3;
   localparam int TIMEOUT = 8;

   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   feed_port_arbiter_if #(.N_PORTS(N), .ID_W(ID_W)) bus();

   feed_port_arbiter #(.N_PORTS(N), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [7:0] drv_data  [N];
   logic       drv_valid [N];
   logic       drv_last  [N];

   always_comb begin
      bus.s_tdata  = '0;
      bus.s_tvalid = '0;
      bus.s_tlast  = '0;
      for (int i = 0; i < N; i++) begin
         bus.s_tdata[i*8 +: 8] = drv_data[i];
         bus.s_tvalid[i]       = drv_valid[i];
         bus.s_tlast[i]        = drv_last[i];
      end
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard / reference model ----------------
   beat_t exp_q [N][$];
   int    grant_log[$];
   bit    in_frame  = 1'b0;
   bit    abort_pend = 1'b0;
   int    exp_gnt   = 0;
   int    exp_ptr   = 0;
   int    frames    = 0;
   int    idle_cnt  = 0;
   int    aborts    = 0;
   int    beat_cnt  = 0;

   always @(negedge clk) begin
      beat_t e;
      if (!rst_n) begin
         check("rst_s_tready", bus.s_tready, 0);
         check("rst_m_tvalid", bus.m_tvalid, 0);
         check("rst_m_tlast", bus.m_tlast, 0);
         check("rst_m_tabort", bus.m_tabort, 0);
         check("rst_m_tid", bus.m_tid, 0);
         check("rst_frame_count", bus.frame_count, 0);
         in_frame   = 1'b0;
         abort_pend = 1'b0;
         exp_ptr    = 0;
         frames     = 0;
         for (int p = 0; p < N; p++) exp_q[p].delete();
      end else begin
         check("frame_count", bus.frame_count, frames & 32'hFFFF);
         if (!in_frame) begin
            check("bubble_m_tvalid", bus.m_tvalid, 0);
            check("bubble_s_tready", bus.s_tready, 0);
            for (int k = 0; k < N; k++) begin
               int p;
               p = (exp_ptr + k) % N;
               if (!in_frame && bus.s_tvalid[p]) begin
                  in_frame = 1'b1;
                  exp_gnt  = p;
                  grant_log.push_back(p);
               end
            end
            idle_cnt   = 0;
            abort_pend = 1'b0;
         end else if (abort_pend) begin
            check("abort_m_tvalid", bus.m_tvalid, 1);
            check("abort_m_tlast", bus.m_tlast, 1);
            check("abort_m_tabort", bus.m_tabort, 1);
            check("abort_m_tdata", bus.m_tdata, 0);
            check("abort_s_tready", bus.s_tready, 0);
            if (bus.m_tready) begin
               in_frame = 1'b0;
               exp_ptr  = (exp_gnt + 1) % N;
               exp_q[exp_gnt].delete();
               aborts++;
            end
         end else begin
            check("pass_m_tvalid", bus.m_tvalid, bus.s_tvalid[exp_gnt]);
            check("pass_s_tready", bus.s_tready, 32'(bus.m_tready) << exp_gnt);
            check("m_tabort_low", bus.m_tabort, 0);
            if (bus.m_tvalid) check("m_tid", bus.m_tid, exp_gnt);
            if (bus.m_tvalid && bus.m_tready) begin
               beat_cnt++;
               if (exp_q[exp_gnt].size() == 0) begin
                  check("unexpected_beat", 0, 1);
               end else begin
                  e = exp_q[exp_gnt].pop_front();
                  check("beat_data", bus.m_tdata, e.data);
                  check("beat_last", bus.m_tlast, e.last);
               end
               if (bus.m_tlast) begin
                  in_frame = 1'b0;
                  exp_ptr  = (exp_gnt + 1) % N;
                  frames++;
               end
               idle_cnt = 0;
            end
`ifdef FEED_ARB_TIMEOUT_EN
            else if (!bus.s_tvalid[exp_gnt]) begin
               idle_cnt++;
               if (idle_cnt == TIMEOUT) abort_pend = 1'b1;
            end
`endif
         end
      end
   end

   // ---------------- parser ready ----------------
   int rdy_mode = 0;   // 0: always ready, 1: random stalls
   initial begin
      bus.m_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.m_tready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(3, 0) != 0);
      end
   end

   // ---------------- port driver ----------------
   task automatic send_frame(input int p, input logic [7:0] bytes[$], input int max_gap,
                             input bit truncate);
      int  n;
      int  budget;
      bit  done;
      n = bytes.size();
      for (int i = 0; i < n; i++) begin
         beat_t b;
         b.data = bytes[i];
         b.last = !truncate && (i == n - 1);
         exp_q[p].push_back(b);
      end
      for (int i = 0; i < n; i++) begin
         int gap;
         gap = (i == 0 || max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0));
         repeat (gap) begin
            drv_valid[p] = 1'b0;
            @(posedge clk);
            #1;
         end
         drv_valid[p] = 1'b1;
         drv_data[p]  = bytes[i];
         drv_last[p]  = !truncate && (i == n - 1);
         done   = 1'b0;
         budget = 0;
         while (!done) begin
            @(negedge clk);
            if (!rst_n) begin
               drv_valid[p] = 1'b0;
               drv_last[p]  = 1'b0;
               return;
            end
            done = bus.s_tready[p];
            @(posedge clk);
            #1;
            budget++;
            if (!done && budget > 3000) begin
               check("driver_beat_budget", 0, 1);
               drv_valid[p] = 1'b0;
               drv_last[p]  = 1'b0;
               return;
            end
         end
      end
      drv_valid[p] = 1'b0;
      drv_last[p]  = 1'b0;
      if (truncate) begin
         repeat (TIMEOUT + 4) @(posedge clk);
         #1;
      end
   endtask

   task automatic send_random(input int p, input int count);
      for (int f = 0; f < count; f++) begin
         logic [7:0] b[$];
         int len;
         len = int'($urandom_range(6, 1));
         for (int i = 0; i < len; i++) b.push_back(8'($urandom));
         send_frame(p, b, 2, 1'b0);
      end
   endtask

   task automatic send_repeat(input int p, input int count, input logic [7:0] base);
      for (int f = 0; f < count; f++) begin
         logic [7:0] b[$];
         b = {base + 8'(f*3), base + 8'(f*3 + 1), base + 8'(f*3 + 2)};
         send_frame(p, b, 0, 1'b0);
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] b[$];
      int log_base;
      int fc0;
      int bc0;
      bit seen;
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) begin
         drv_valid[i] = 1'b0;
         drv_data[i]  = 8'h00;
         drv_last[i]  = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Basic 4-byte frame on port 0.
      b = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
      send_frame(0, b, 0, 1'b0);
      check("t1_frame_count", bus.frame_count, 1);
      check("t1_grant", grant_log[grant_log.size()-1], 0);

      // Both ports hammering 3-byte frames: grants must alternate.
      log_base = grant_log.size();
      fork
         send_repeat(0, 4, 8'h10);
         send_repeat(1, 4, 8'h80);
      join
      for (int k = log_base + 1; k < log_base + 8; k++)
         check("t2_alternate", grant_log[k], grant_log[k-1] ^ 1);

      // Port 1 requests mid-frame while the parser stalls.
      rdy_mode = 1;
      fork
         begin
            b = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
            send_frame(0, b, 1, 1'b0);
         end
         begin
            logic [7:0] c[$];
            repeat (3) @(posedge clk);
            #1;
            c = {8'hE1, 8'hE2};
            send_frame(1, c, 0, 1'b0);
         end
      join
      rdy_mode = 0;

      // Single-byte frame on port 1.
      fc0 = bus.frame_count;
      b = {8'h55};
      send_frame(1, b, 0, 1'b0);
      check("t4_grant", grant_log[grant_log.size()-1], 1);
      check("t4_frame_count", bus.frame_count, (fc0 + 1) & 32'hFFFF);
      check("t4_idle_after", bus.m_tvalid, 0);

      // Randomized traffic with gaps and stalls.
      rdy_mode = 1;
      fork
         send_random(0, 20);
         send_random(1, 20);
      join
      rdy_mode = 0;
      repeat (3) @(posedge clk);
      #1;

      // Reset on byte 2 of a 5-byte frame; port 0 first leaves ptr at 1.
      b = {8'h11};
      send_frame(0, b, 0, 1'b0);
      bc0 = beat_cnt;
      fork
         begin
            b = {8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
            send_frame(0, b, 0, 1'b0);
         end
         begin
            seen = 1'b0;
            for (int t = 0; t < 50 && !seen; t++) begin
               @(negedge clk);
               seen = (beat_cnt == bc0 + 1);
            end
            check("t6_first_byte_seen", seen, 1);
            @(posedge clk);
            #3 rst_n = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
         end
      join
      check("t6_frame_count_cleared", bus.frame_count, 0);
      log_base = grant_log.size();
      fork
         begin
            logic [7:0] c[$];
            c = {8'h31, 8'h32};
            send_frame(0, c, 0, 1'b0);
         end
         begin
            logic [7:0] c[$];
            c = {8'h41, 8'h42};
            send_frame(1, c, 0, 1'b0);
         end
      join
      check("t6_grant_after_reset", grant_log[log_base], 0);
      check("t6_second_grant", grant_log[log_base + 1], 1);

`ifdef FEED_ARB_TIMEOUT_EN
      // Port 0 stalls mid-frame; watchdog aborts, port 1 follows.
      fc0 = bus.frame_count;
      fork
         begin
            b = {8'hA1, 8'hA2};
            send_frame(0, b, 0, 1'b1);
         end
         begin
            logic [7:0] c[$];
            repeat (5) @(posedge clk);
            #1;
            c = {8'h77};
            send_frame(1, c, 0, 1'b0);
         end
      join
      check("t7_aborts", aborts, 1);
      check("t7_frame_count", bus.frame_count, (fc0 + 1) & 32'hFFFF);
      check("t7_grant_after_abort", grant_log[grant_log.size()-1], 1);
`endif

      repeat (5) @(posedge clk);
      #1;
      for (int p = 0; p < N; p++) check("queue_drained", exp_q[p].size(), 0);
      check("final_idle_m_tvalid", bus.m_tvalid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
